// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-master memory arbiter: grant-register state
// encodings, the grant-index type and a helper mapping an index to its state.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_GNT0 = 2'd1,
        ARB_GNT1 = 2'd2
    } arb_state_t;

    // Master index: 0 = stim (vector reads), 1 = check (result writeback)
    typedef logic gnt_idx_t;

    function automatic arb_state_t gnt_state(input gnt_idx_t idx);
        return idx ? ARB_GNT1 : ARB_GNT0;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Two-way round-robin chooser. On a tie the master that was not served last
// wins; otherwise the single requester wins. Purely combinational.
import mem_arbiter_pkg::*;

module rr_pick (
    input  logic [1:0] req,
    input  gnt_idx_t   last,
    output gnt_idx_t   pick,
    output logic       valid
);

    // Tie goes to the master opposite the last one served
    always_comb begin
        valid = |req;
        if (&req) begin
            pick = ~last;
        end else begin
            pick = req[1];
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one Avalon-MM slave between two masters with a registered round-robin
// grant. A master holding lock keeps the grant for up to LOCK_MAX consecutive
// beats so a multi-word record lands contiguously.
import mem_arbiter_pkg::*;

module mem_arbiter #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 16,
    parameter int BE_WIDTH   = DATA_WIDTH / 8,
    parameter int LOCK_MAX   = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] m0_address,
    input  logic [BE_WIDTH-1:0]   m0_byteenable,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_WIDTH-1:0] m0_writedata,
    input  logic                  m0_lock,
    output logic [DATA_WIDTH-1:0] m0_readdata,
    output logic                  m0_waitrequest,
    input  logic [ADDR_WIDTH-1:0] m1_address,
    input  logic [BE_WIDTH-1:0]   m1_byteenable,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_WIDTH-1:0] m1_writedata,
    input  logic                  m1_lock,
    output logic [DATA_WIDTH-1:0] m1_readdata,
    output logic                  m1_waitrequest,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [BE_WIDTH-1:0]   mem_byteenable,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [DATA_WIDTH-1:0] mem_writedata,
    input  logic [DATA_WIDTH-1:0] mem_readdata,
    input  logic                  mem_waitrequest,
    output logic                  err_rw
);

    // Wide enough to hold LOCK_MAX-1 even when LOCK_MAX is 1
    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    logic [ADDR_WIDTH-1:0] mst_address    [2];
    logic [BE_WIDTH-1:0]   mst_byteenable [2];
    logic [DATA_WIDTH-1:0] mst_writedata  [2];
    logic [1:0]            mst_read;
    logic [1:0]            mst_write;
    logic [1:0]            mst_lock;
    logic [1:0]            req;
    logic [1:0]            wait_vec;

    arb_state_t            state_reg, state_next;
    gnt_idx_t              last_reg, last_next;
    logic [CNT_W-1:0]      lock_cnt_reg, lock_cnt_next;
    logic                  err_rw_reg, err_rw_next;

    logic                  granted;
    gnt_idx_t              sel;
    gnt_idx_t              arb_last;
    gnt_idx_t              pick;
    logic                  pick_valid;
    logic                  rearb;

    assign mst_address[0]    = m0_address;
    assign mst_address[1]    = m1_address;
    assign mst_byteenable[0] = m0_byteenable;
    assign mst_byteenable[1] = m1_byteenable;
    assign mst_writedata[0]  = m0_writedata;
    assign mst_writedata[1]  = m1_writedata;
    assign mst_read          = {m1_read, m0_read};
    assign mst_write         = {m1_write, m0_write};
    assign mst_lock          = {m1_lock, m0_lock};

    assign granted = (state_reg != ARB_IDLE);
    assign sel     = (state_reg == ARB_GNT1);

    // Per-master request and stall: only the granted master sees the slave's waitrequest
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_master
            assign req[gi]      = mst_read[gi] | mst_write[gi];
            assign wait_vec[gi] = (granted && (int'(sel) == gi)) ? mem_waitrequest : 1'b1;
        end
    endgenerate

    assign m0_waitrequest = wait_vec[0];
    assign m1_waitrequest = wait_vec[1];
    assign m0_readdata    = mem_readdata;
    assign m1_readdata    = mem_readdata;

    // Forward the granted master; read+write together is forwarded as a write only
    assign mem_address    = mst_address[sel];
    assign mem_byteenable = mst_byteenable[sel];
    assign mem_writedata  = mst_writedata[sel];
    assign mem_write      = granted && mst_write[sel];
    assign mem_read       = granted && mst_read[sel] && !mst_write[sel];
    assign err_rw         = err_rw_reg;

    // While granted, re-arbitration treats the current holder as last served
    assign arb_last = granted ? sel : last_reg;

    rr_pick u_rr_pick (
        .req   (req),
        .last  (arb_last),
        .pick  (pick),
        .valid (pick_valid)
    );

    // Next grant: hold while stalled, extend on lock, otherwise re-arbitrate
    always_comb begin
        state_next    = state_reg;
        last_next     = last_reg;
        lock_cnt_next = lock_cnt_reg;
        err_rw_next   = err_rw_reg | (granted && mst_read[sel] && mst_write[sel]);
        rearb         = 1'b0;
        if (!granted) begin
            if (pick_valid) begin
                state_next = gnt_state(pick);
            end
        end else if (req[sel]) begin
            if (!mem_waitrequest) begin
                if (mst_lock[sel] && (lock_cnt_reg < CNT_W'(LOCK_MAX - 1))) begin
                    lock_cnt_next = lock_cnt_reg + 1'b1;
                end else begin
                    rearb = 1'b1;
                end
            end
        end else if (!mst_lock[sel]) begin
            rearb = 1'b1;
        end
        if (rearb) begin
            lock_cnt_next = '0;
            last_next     = sel;
            state_next    = pick_valid ? gnt_state(pick) : ARB_IDLE;
        end
    end

    // Grant, round-robin history, lock beat count and sticky error flag
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= ARB_IDLE;
            last_reg     <= 1'b1;
            lock_cnt_reg <= '0;
            err_rw_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            last_reg     <= last_next;
            lock_cnt_reg <= lock_cnt_next;
            err_rw_reg   <= err_rw_next;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: reset checks, a cycle-by-cycle vector table, hand
// sequences for lock / starvation bound / read+write error, and random traffic
// checked against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;

    localparam int AW = 20;
    localparam int DW = 16;
    localparam int BW = 2;
    localparam int LOCK_MAX = 4;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic [AW-1:0] m0_address, m1_address, mem_address;
    logic [BW-1:0] m0_byteenable, m1_byteenable, mem_byteenable;
    logic          m0_read, m0_write, m0_lock, m0_waitrequest;
    logic          m1_read, m1_write, m1_lock, m1_waitrequest;
    logic [DW-1:0] m0_writedata, m1_writedata, mem_writedata;
    logic [DW-1:0] m0_readdata, m1_readdata, mem_readdata;
    logic          mem_read, mem_write, mem_waitrequest, err_rw;

    int total = 0;
    int bad   = 0;

    // Model: owner -1 = nobody, 0/1 = master holding the bus
    int owner;
    int last_served;
    int locked_beats;
    bit err_seen;

    always #5 clock = ~clock;

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .LOCK_MAX(LOCK_MAX)) dut (
        .clock(clock), .reset_n(reset_n),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_lock(m0_lock),
        .m0_readdata(m0_readdata), .m0_waitrequest(m0_waitrequest),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_lock(m1_lock),
        .m1_readdata(m1_readdata), .m1_waitrequest(m1_waitrequest),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_read(mem_read),
        .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
        .mem_waitrequest(mem_waitrequest), .err_rw(err_rw)
    );

    typedef struct {
        logic r0, w0, l0, r1, w1, l1, mw;
        logic [DW-1:0] rdata;
        logic e_w0, e_w1, e_rd, e_wr;
        logic [AW-1:0] e_addr;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
        end
    endtask

    function automatic int choose(input bit q0, input bit q1, input int prev);
        if (q0 && q1) return 1 - prev;
        if (q0) return 0;
        if (q1) return 1;
        return -1;
    endfunction

    task automatic model_reset();
        owner = -1;
        last_served = 1;
        locked_beats = 0;
        err_seen = 1'b0;
    endtask

    // Expected outputs for the current cycle, from who owns the bus
    task automatic model_check();
        logic ew0, ew1, erd, ewr;
        ew0 = (owner == 0) ? mem_waitrequest : 1'b1;
        ew1 = (owner == 1) ? mem_waitrequest : 1'b1;
        erd = 1'b0;
        ewr = 1'b0;
        if (owner == 0) begin
            ewr = m0_write;
            erd = m0_read && !m0_write;
        end else if (owner == 1) begin
            ewr = m1_write;
            erd = m1_read && !m1_write;
        end
        chk("model m0_waitrequest", m0_waitrequest, ew0);
        chk("model m1_waitrequest", m1_waitrequest, ew1);
        chk("model mem_read", mem_read, erd);
        chk("model mem_write", mem_write, ewr);
        chk("model err_rw", err_rw, err_seen);
        chk("model m0_readdata", m0_readdata, mem_readdata);
        chk("model m1_readdata", m1_readdata, mem_readdata);
        if (owner == 0) begin
            chk("model mem_address", mem_address, m0_address);
            chk("model mem_writedata", mem_writedata, m0_writedata);
            chk("model mem_byteenable", mem_byteenable, m0_byteenable);
        end else if (owner == 1) begin
            chk("model mem_address", mem_address, m1_address);
            chk("model mem_writedata", mem_writedata, m1_writedata);
            chk("model mem_byteenable", mem_byteenable, m1_byteenable);
        end
    endtask

    // Ownership update at the clock edge, from the arbitration rules
    task automatic model_step();
        bit q0, q1, q_own, lk_own, rd_own, wr_own;
        q0 = m0_read | m0_write;
        q1 = m1_read | m1_write;
        if (owner < 0) begin
            owner = choose(q0, q1, last_served);
            return;
        end
        rd_own = (owner == 0) ? m0_read : m1_read;
        wr_own = (owner == 0) ? m0_write : m1_write;
        lk_own = (owner == 0) ? m0_lock : m1_lock;
        q_own  = rd_own | wr_own;
        if (rd_own && wr_own) err_seen = 1'b1;
        if (q_own && mem_waitrequest) return;      // stalled beat: grant frozen
        if (q_own && lk_own && (locked_beats + 1 < LOCK_MAX)) begin
            locked_beats++;                         // locked beat done, keep bus
            return;
        end
        if (!q_own && lk_own) return;               // locked and idle between beats
        locked_beats = 0;
        last_served = owner;
        owner = choose(q0, q1, last_served);
    endtask

    task automatic settle();
        @(negedge clock);
        model_check();
    endtask

    task automatic advance();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic cycle();
        settle();
        advance();
    endtask

    task automatic clear_inputs();
        m0_address = '0; m0_byteenable = '1; m0_read = 0; m0_write = 0; m0_writedata = '0; m0_lock = 0;
        m1_address = '0; m1_byteenable = '1; m1_read = 0; m1_write = 0; m1_writedata = '0; m1_lock = 0;
        mem_readdata = '0; mem_waitrequest = 0;
    endtask

    task automatic idle_all(input int n);
        clear_inputs();
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        clear_inputs();
        reset_n = 1'b0;
        model_reset();
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        model_check();                              // outputs while held in reset
        reset_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic add_vec(input logic r0, w0, l0, r1, w1, l1, mw, input logic [DW-1:0] rdata,
                           input logic e_w0, e_w1, e_rd, e_wr, input logic [AW-1:0] e_addr);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.l0 = l0; v.r1 = r1; v.w1 = w1; v.l1 = l1; v.mw = mw;
        v.rdata = rdata; v.e_w0 = e_w0; v.e_w1 = e_w1; v.e_rd = e_rd; v.e_wr = e_wr; v.e_addr = e_addr;
        vecs.push_back(v);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got still running want finished");
        $fatal(1);
    end

    initial begin
        int m1_beats;
        bit m0_got;
        bit rw_ok;
        int sel_op;

        // Both masters requesting: alternating grants, then a lone read with stalls
        //       r0 w0 l0 r1 w1 l1 mw  rdata    ew0 ew1 erd ewr addr
        add_vec(1, 0, 0, 1, 0, 0, 0, 16'h0000, 1,  1,  0,  0,  20'h0);
        add_vec(1, 0, 0, 1, 0, 0, 0, 16'h1111, 0,  1,  1,  0,  20'h10);
        add_vec(1, 0, 0, 1, 0, 0, 0, 16'h2222, 1,  0,  1,  0,  20'h20);
        add_vec(1, 0, 0, 1, 0, 0, 0, 16'h3333, 0,  1,  1,  0,  20'h10);
        add_vec(1, 0, 0, 1, 0, 0, 0, 16'h4444, 1,  0,  1,  0,  20'h20);
        add_vec(0, 0, 0, 0, 0, 0, 0, 16'h5555, 0,  1,  0,  0,  20'h0);
        add_vec(0, 0, 0, 0, 0, 0, 0, 16'h6666, 1,  1,  0,  0,  20'h0);
        add_vec(1, 0, 0, 0, 0, 0, 1, 16'h0000, 1,  1,  0,  0,  20'h0);
        add_vec(1, 0, 0, 0, 0, 0, 1, 16'h0000, 1,  1,  1,  0,  20'h10);
        add_vec(1, 0, 0, 0, 0, 0, 1, 16'h0000, 1,  1,  1,  0,  20'h10);
        add_vec(1, 0, 0, 0, 0, 0, 0, 16'hBEEF, 0,  1,  1,  0,  20'h10);
        add_vec(0, 0, 0, 0, 0, 0, 0, 16'h0000, 0,  1,  0,  0,  20'h0);
        add_vec(0, 0, 0, 0, 0, 0, 0, 16'h0000, 1,  1,  0,  0,  20'h0);

        clear_inputs();
        model_reset();
        do_reset();

        foreach (vecs[i]) begin
            m0_address = 20'h00010; m1_address = 20'h00020;
            m0_read = vecs[i].r0; m0_write = vecs[i].w0; m0_lock = vecs[i].l0;
            m1_read = vecs[i].r1; m1_write = vecs[i].w1; m1_lock = vecs[i].l1;
            mem_waitrequest = vecs[i].mw; mem_readdata = vecs[i].rdata;
            settle();
            chk($sformatf("vec%0d m0_waitrequest", i), m0_waitrequest, vecs[i].e_w0);
            chk($sformatf("vec%0d m1_waitrequest", i), m1_waitrequest, vecs[i].e_w1);
            chk($sformatf("vec%0d mem_read", i), mem_read, vecs[i].e_rd);
            chk($sformatf("vec%0d mem_write", i), mem_write, vecs[i].e_wr);
            chk($sformatf("vec%0d m0_readdata", i), m0_readdata, vecs[i].rdata);
            if (vecs[i].e_rd || vecs[i].e_wr)
                chk($sformatf("vec%0d mem_address", i), mem_address, vecs[i].e_addr);
            advance();
        end

        // Locked two-word record from m1 while m0 waits
        m0_address = 20'h00010; m0_read = 1;
        m1_address = 20'h00100; m1_write = 1; m1_lock = 1; m1_writedata = 16'hA001;
        mem_waitrequest = 0;
        cycle();
        settle();
        chk("rec beat1 mem_write", mem_write, 1'b1);
        chk("rec beat1 writedata", mem_writedata, 16'hA001);
        chk("rec beat1 m0_waitrequest", m0_waitrequest, 1'b1);
        advance();
        m1_writedata = 16'hA002; m1_lock = 0; m1_address = 20'h00101;
        settle();
        chk("rec beat2 mem_write", mem_write, 1'b1);
        chk("rec beat2 writedata", mem_writedata, 16'hA002);
        chk("rec beat2 m1_waitrequest", m1_waitrequest, 1'b0);
        advance();
        m1_write = 0;
        settle();
        chk("rec after m0_waitrequest", m0_waitrequest, 1'b0);
        chk("rec after mem_read", mem_read, 1'b1);
        advance();
        idle_all(3);

        // Permanent lock on m1: starvation bound hands m0 the bus after LOCK_MAX beats
        m1_address = 20'h00200; m1_write = 1; m1_lock = 1; mem_waitrequest = 0;
        cycle();
        m0_address = 20'h00010; m0_read = 1;
        m1_beats = 0;
        m0_got = 0;
        for (int i = 0; i < 20; i++) begin
            settle();
            if (!m1_waitrequest && mem_write) m1_beats++;
            if (!m0_waitrequest && mem_read) begin
                m0_got = 1;
                advance();
                break;
            end
            advance();
        end
        chk("lockmax m0 granted in bound", m0_got, 1'b1);
        chk("lockmax m1 beats", m1_beats, LOCK_MAX);
        idle_all(3);

        // Ungranted master driving read and write is not flagged
        do_reset();
        m1_address = 20'h00300; m1_read = 1; m1_lock = 1; mem_waitrequest = 1;
        cycle();
        m0_read = 1; m0_write = 1;
        for (int i = 0; i < 3; i++) cycle();
        settle();
        chk("ungranted rw err_rw", err_rw, 1'b0);
        advance();

        // Reset mid-transfer drops the strobe immediately
        do_reset();
        m0_address = 20'h00040; m0_read = 1; mem_waitrequest = 1;
        cycle();
        settle();
        chk("abort before mem_read", mem_read, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort mem_read", mem_read, 1'b0);
        chk("abort m0_waitrequest", m0_waitrequest, 1'b1);
        do_reset();

        // Granted read+write: forwarded as write, sticky error until reset
        m1_address = 20'h00002; m1_read = 1; m1_write = 1; m1_writedata = 16'h1234;
        mem_waitrequest = 0;
        cycle();
        settle();
        chk("rw mem_write", mem_write, 1'b1);
        chk("rw mem_read", mem_read, 1'b0);
        chk("rw mem_writedata", mem_writedata, 16'h1234);
        chk("rw mem_address", mem_address, 20'h00002);
        advance();
        idle_all(4);
        settle();
        chk("rw err_rw sticky", err_rw, 1'b1);
        advance();
        do_reset();
        settle();
        chk("rw err_rw cleared", err_rw, 1'b0);
        advance();

        // Random traffic against the model
        for (int ep = 0; ep < 6; ep++) begin
            do_reset();
            rw_ok = ep[0];
            for (int n = 0; n < 300; n++) begin
                sel_op = $urandom_range(0, 3);
                m0_read  = (sel_op == 1) || (sel_op == 3);
                m0_write = (sel_op == 2) || (sel_op == 3 && rw_ok && $urandom_range(0, 3) == 0);
                sel_op = $urandom_range(0, 3);
                m1_read  = (sel_op == 1) || (sel_op == 3);
                m1_write = (sel_op == 2) || (sel_op == 3 && rw_ok && $urandom_range(0, 3) == 0);
                m0_lock = 1'($urandom_range(0, 1));
                m1_lock = 1'($urandom_range(0, 1));
                m0_address = AW'($urandom); m1_address = AW'($urandom);
                m0_byteenable = BW'($urandom); m1_byteenable = BW'($urandom);
                m0_writedata = DW'($urandom); m1_writedata = DW'($urandom);
                mem_readdata = DW'($urandom);
                mem_waitrequest = ($urandom_range(0, 2) == 0);
                cycle();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
